// File: rtl/rvcpu_ram_arbiter_pkg.sv
// rtl/rvcpu_ram_arbiter_pkg.sv - shared state, owner and size encodings for the RAM arbiter
package rvcpu_ram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } arb_owner_t;

   localparam logic [2:0] RAM_SIZE_B = 3'b000;
   localparam logic [2:0] RAM_SIZE_H = 3'b001;
   localparam logic [2:0] RAM_SIZE_W = 3'b010;
   localparam logic [2:0] RAM_SIZE_D = 3'b011;

endpackage

// File: rtl/rvcpu_ram_arbiter.sv
// rtl/rvcpu_ram_arbiter.sv - fixed-priority IFU/LSU arbiter onto the single ram_rw port
module rvcpu_ram_arbiter
   import rvcpu_ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ifu_req_i,
   input  logic [ADDR_W-1:0]   ifu_addr_i,
   output logic                ifu_ready_o,
   output logic [31:0]         ifu_rdata_o,
   input  logic                lsu_req_i,
   input  logic                lsu_wen_i,
   input  logic [ADDR_W-1:0]   lsu_addr_i,
   input  logic [DATA_W-1:0]   lsu_wdata_i,
   input  logic [DATA_W/8-1:0] lsu_wmask_i,
   input  logic [2:0]          lsu_size_i,
   output logic                lsu_ready_o,
   output logic [DATA_W-1:0]   lsu_rdata_o,
   output logic                ram_rw_cen_o,
   output logic                ram_rw_wen_o,
   output logic [ADDR_W-1:0]   ram_rw_addr_o,
   output logic [DATA_W-1:0]   ram_rw_wdata_o,
   output logic [DATA_W/8-1:0] ram_rw_wmask_o,
   output logic [2:0]          ram_rw_size_o,
   input  logic                ram_rw_ready_i,
   input  logic [DATA_W-1:0]   ram_rw_data_i
);

   arb_state_t          r_state, w_state_nxt;
   arb_owner_t          r_owner, w_owner_nxt;
   logic                r_cen, w_cen_nxt;
   logic                r_wen, w_wen_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
   logic [DATA_W/8-1:0] r_wmask, w_wmask_nxt;
   logic [2:0]          r_size, w_size_nxt;
   logic                r_ifu_ready, w_ifu_ready_nxt;
   logic                r_lsu_ready, w_lsu_ready_nxt;
   logic [31:0]         r_ifu_rdata, w_ifu_rdata_nxt;
   logic [DATA_W-1:0]   r_lsu_rdata, w_lsu_rdata_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_IFU;
         r_cen       <= 1'b0;
         r_wen       <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wmask     <= '0;
         r_size      <= '0;
         r_ifu_ready <= 1'b0;
         r_lsu_ready <= 1'b0;
         r_ifu_rdata <= '0;
         r_lsu_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_cen       <= w_cen_nxt;
         r_wen       <= w_wen_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_wmask     <= w_wmask_nxt;
         r_size      <= w_size_nxt;
         r_ifu_ready <= w_ifu_ready_nxt;
         r_lsu_ready <= w_lsu_ready_nxt;
         r_ifu_rdata <= w_ifu_rdata_nxt;
         r_lsu_rdata <= w_lsu_rdata_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_cen_nxt       = r_cen;
      w_wen_nxt       = r_wen;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_wmask_nxt     = r_wmask;
      w_size_nxt      = r_size;
      w_ifu_ready_nxt = 1'b0;
      w_lsu_ready_nxt = 1'b0;
      w_ifu_rdata_nxt = r_ifu_rdata;
      w_lsu_rdata_nxt = r_lsu_rdata;
      case (r_state)
         ST_IDLE: begin
            if (lsu_req_i) begin
               w_owner_nxt = OWN_LSU;
               w_cen_nxt   = 1'b1;
               w_wen_nxt   = lsu_wen_i;
               w_addr_nxt  = lsu_addr_i;
               w_wdata_nxt = lsu_wdata_i;
               w_wmask_nxt = lsu_wmask_i;
               w_size_nxt  = lsu_size_i;
               w_state_nxt = ST_WAIT;
            end else if (ifu_req_i) begin
               w_owner_nxt = OWN_IFU;
               w_cen_nxt   = 1'b1;
               w_wen_nxt   = 1'b0;
               w_addr_nxt  = ifu_addr_i;
               w_wmask_nxt = '0;
               w_size_nxt  = RAM_SIZE_W;
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (ram_rw_ready_i) begin
               w_cen_nxt   = 1'b0;
               w_wen_nxt   = 1'b0;
               w_state_nxt = ST_DRAIN;
               if (r_owner == OWN_LSU) begin
                  w_lsu_ready_nxt = 1'b1;
                  w_lsu_rdata_nxt = ram_rw_data_i;
               end else begin
                  w_ifu_ready_nxt = 1'b1;
                  w_ifu_rdata_nxt = r_addr[2] ? ram_rw_data_i[DATA_W-1:DATA_W/2]
                                              : ram_rw_data_i[DATA_W/2-1:0];
               end
            end
         end
         // Responder still shows ready for the last cen cycle; skip it and let the client drop req.
         ST_DRAIN: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   assign ifu_ready_o    = r_ifu_ready;
   assign ifu_rdata_o    = r_ifu_rdata;
   assign lsu_ready_o    = r_lsu_ready;
   assign lsu_rdata_o    = r_lsu_rdata;
   assign ram_rw_cen_o   = r_cen;
   assign ram_rw_wen_o   = r_wen;
   assign ram_rw_addr_o  = r_addr;
   assign ram_rw_wdata_o = r_wdata;
   assign ram_rw_wmask_o = r_wmask;
   assign ram_rw_size_o  = r_size;

endmodule

// File: tb/tb_rvcpu_ram_arbiter.sv
// tb/tb_rvcpu_ram_arbiter.sv - randomized bench for rvcpu_ram_arbiter with a transaction-level reference model
module tb_rvcpu_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_i;
   logic [63:0] ifu_addr_i;
   logic        ifu_ready_o;
   logic [31:0] ifu_rdata_o;
   logic        lsu_req_i;
   logic        lsu_wen_i;
   logic [63:0] lsu_addr_i;
   logic [63:0] lsu_wdata_i;
   logic [7:0]  lsu_wmask_i;
   logic [2:0]  lsu_size_i;
   logic        lsu_ready_o;
   logic [63:0] lsu_rdata_o;
   logic        ram_rw_cen_o;
   logic        ram_rw_wen_o;
   logic [63:0] ram_rw_addr_o;
   logic [63:0] ram_rw_wdata_o;
   logic [7:0]  ram_rw_wmask_o;
   logic [2:0]  ram_rw_size_o;
   logic        ram_rw_ready_i;
   logic [63:0] ram_rw_data_i;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rvcpu_ram_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i),
      .ifu_ready_o(ifu_ready_o), .ifu_rdata_o(ifu_rdata_o),
      .lsu_req_i(lsu_req_i), .lsu_wen_i(lsu_wen_i), .lsu_addr_i(lsu_addr_i),
      .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i), .lsu_size_i(lsu_size_i),
      .lsu_ready_o(lsu_ready_o), .lsu_rdata_o(lsu_rdata_o),
      .ram_rw_cen_o(ram_rw_cen_o), .ram_rw_wen_o(ram_rw_wen_o),
      .ram_rw_addr_o(ram_rw_addr_o), .ram_rw_wdata_o(ram_rw_wdata_o),
      .ram_rw_wmask_o(ram_rw_wmask_o), .ram_rw_size_o(ram_rw_size_o),
      .ram_rw_ready_i(ram_rw_ready_i), .ram_rw_data_i(ram_rw_data_i)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] init_word(input int idx);
      return {16'hC0DE, idx[15:0], ~idx[15:0], 16'h5EED};
   endfunction

   // Responder memory (written by the port) and reference memory (updated per completed store).
   logic [63:0] ram_mem   [int];
   logic [63:0] model_mem [int];

   function automatic logic [63:0] model_rd(input logic [63:0] a);
      int idx = int'(a[6:3]);
      return model_mem.exists(idx) ? model_mem[idx] : init_word(idx);
   endfunction

   int resp_delay = 0;
   int resp_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_rw_ready_i <= 1'b0;
         ram_rw_data_i  <= '0;
         resp_cnt       <= 0;
      end else if (!ram_rw_cen_o) begin
         ram_rw_ready_i <= 1'b0;
         resp_cnt       <= 0;
      end else begin
         int          idx;
         logic [63:0] w;
         idx = int'(ram_rw_addr_o[6:3]);
         w   = ram_mem.exists(idx) ? ram_mem[idx] : init_word(idx);
         ram_rw_data_i  <= w;
         ram_rw_ready_i <= (resp_cnt >= resp_delay);
         resp_cnt       <= resp_cnt + 1;
         if (ram_rw_wen_o) begin
            for (int b = 0; b < 8; b++)
               if (ram_rw_wmask_o[b]) w[8*b +: 8] = ram_rw_wdata_o[8*b +: 8];
            ram_mem[idx] = w;
         end
      end
   end

   // Reference timing: grant at edge 0, cen high through edge 1+dly, ready pulse after edge 2+dly,
   // idle after edge 3+dly; a still-pending second client is granted on the following edge.
   task automatic run_txn(input bit do_ifu, input bit do_lsu, input int dly,
                          input logic [63:0] iaddr, input bit lwen, input logic [63:0] laddr,
                          input logic [63:0] lwdata, input logic [7:0] lmask, input logic [2:0] lsize);
      bit owners[$];
      resp_delay  = dly;
      ifu_req_i   = do_ifu;
      ifu_addr_i  = iaddr;
      lsu_req_i   = do_lsu;
      lsu_wen_i   = lwen;
      lsu_addr_i  = laddr;
      lsu_wdata_i = lwdata;
      lsu_wmask_i = lmask;
      lsu_size_i  = lsize;
      if (do_lsu) owners.push_back(1'b1);
      if (do_ifu) owners.push_back(1'b0);
      foreach (owners[o]) begin
         bit is_lsu = owners[o];
         for (int k = 0; k <= 3 + dly; k++) begin
            bit exp_cen = (k <= 1 + dly);
            @(posedge clk);
            @(negedge clk);
            check("cen", ram_rw_cen_o, exp_cen);
            if (exp_cen) begin
               check("wen",   ram_rw_wen_o,   is_lsu ? lwen  : 1'b0);
               check("addr",  ram_rw_addr_o,  is_lsu ? laddr : iaddr);
               check("wmask", ram_rw_wmask_o, is_lsu ? lmask : 8'h00);
               check("size",  ram_rw_size_o,  is_lsu ? lsize : 3'b010);
               if (is_lsu) check("wdata", ram_rw_wdata_o, lwdata);
            end
            check("ifu_ready", ifu_ready_o, !is_lsu && k == 2 + dly);
            check("lsu_ready", lsu_ready_o,  is_lsu && k == 2 + dly);
            if (k == 2 + dly) begin
               if (is_lsu) begin
                  logic [63:0] w = model_rd(laddr);
                  if (lwen) begin
                     for (int b = 0; b < 8; b++)
                        if (lmask[b]) w[8*b +: 8] = lwdata[8*b +: 8];
                     model_mem[int'(laddr[6:3])] = w;
                  end else begin
                     check("lsu_rdata", lsu_rdata_o, w);
                  end
                  lsu_req_i = 1'b0;
               end else begin
                  logic [63:0] w = model_rd(iaddr);
                  check("ifu_rdata", {32'h0, ifu_rdata_o}, {32'h0, iaddr[2] ? w[63:32] : w[31:0]});
                  ifu_req_i = 1'b0;
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("idle_cen", ram_rw_cen_o, 1'b0);
      check("idle_rdy", {ifu_ready_o, lsu_ready_o}, 2'b00);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      ifu_req_i = 0; ifu_addr_i = 0; lsu_req_i = 0; lsu_wen_i = 0;
      lsu_addr_i = 0; lsu_wdata_i = 0; lsu_wmask_i = 0; lsu_size_i = 0;
      repeat (3) @(negedge clk);
      check("rst_cen",   ram_rw_cen_o,   1'b0);
      check("rst_wen",   ram_rw_wen_o,   1'b0);
      check("rst_addr",  ram_rw_addr_o,  64'h0);
      check("rst_wdata", ram_rw_wdata_o, 64'h0);
      check("rst_wmask", ram_rw_wmask_o, 8'h0);
      check("rst_size",  ram_rw_size_o,  3'h0);
      check("rst_rdy",   {ifu_ready_o, lsu_ready_o}, 2'b00);
      check("rst_irdat", {32'h0, ifu_rdata_o}, 64'h0);
      check("rst_lrdat", lsu_rdata_o, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Preload the fetch word, then a single fetch of its upper half.
      run_txn(0, 1, 0, 64'h0, 1, 64'h8000_0000, 64'h00A0_0513_0010_0093, 8'hFF, 3'b011);
      run_txn(1, 0, 0, 64'h8000_0004, 0, 64'h0, 64'h0, 8'h0, 3'b0);
      check("fetch_word", {32'h0, ifu_rdata_o}, 64'h0000_0000_00A0_0513);

      // Byte store into lane 4, then read the beat back.
      run_txn(0, 1, 0, 64'h0, 1, 64'h8000_0010, 64'h0000_00EF_0000_0000, 8'h10, 3'b000);
      run_txn(0, 1, 0, 64'h0, 0, 64'h8000_0010, 64'h0, 8'h0, 3'b011);
      check("store_byte4", {56'h0, lsu_rdata_o[39:32]}, 64'hEF);

      // Collision, then slow responder.
      run_txn(1, 1, 0, 64'h8000_0010, 0, 64'h8000_0018, 64'h0, 8'h0, 3'b011);
      run_txn(1, 0, 5, 64'h8000_0020, 0, 64'h0, 64'h0, 8'h0, 3'b0);
      run_txn(1, 1, 5, 64'h8000_0014, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hF0, 3'b011);

      for (int t = 0; t < 60; t++) begin
         int sel = $urandom_range(1, 3);
         run_txn(sel[0], sel[1], $urandom_range(0, 5),
                 64'h8000_0000 + 64'($urandom_range(0, 31) * 4),
                 1'($urandom_range(0, 1)),
                 64'h8000_0000 + 64'($urandom_range(0, 15) * 8),
                 {$urandom, $urandom}, 8'($urandom), 3'($urandom));
      end

      // Reset while waiting on a slow responder (mask 0 so memory stays unchanged).
      resp_delay = 4;
      lsu_req_i = 1; lsu_wen_i = 1; lsu_addr_i = 64'h8000_0008;
      lsu_wdata_i = 64'hDEAD_BEEF_0000_0001; lsu_wmask_i = 8'h00; lsu_size_i = 3'b011;
      @(posedge clk);
      @(negedge clk);
      check("mid_cen_on", ram_rw_cen_o, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_cen_async", ram_rw_cen_o, 1'b0);
      check("mid_wen_async", ram_rw_wen_o, 1'b0);
      lsu_req_i = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("post_rst_cen", ram_rw_cen_o, 1'b0);
         check("post_rst_rdy", {ifu_ready_o, lsu_ready_o}, 2'b00);
      end

      // Arbiter must be back in IDLE and serve normally.
      run_txn(1, 0, 1, 64'h8000_0004, 0, 64'h0, 64'h0, 8'h0, 3'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
